// File: rtl/alu_pipe_pkg.sv
// Shared types for the pipelined ALU: opcode encoding, status flag bundle
// and the legal-opcode predicate.
package alu_pipe_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'b0000,
    OP_SUB = 4'b0001,
    OP_INC = 4'b0010,
    OP_DEC = 4'b0011,
    OP_AND = 4'b0101,
    OP_OR  = 4'b0110,
    OP_XOR = 4'b0111,
    OP_SHL = 4'b1000,
    OP_SHR = 4'b1001,
    OP_SRA = 4'b1010,
    OP_CMP = 4'b1011
  } opcode_e;

  typedef struct packed {
    logic carry_out;
    logic zero;
    logic overflow;
    logic err;
  } flags_t;

  function automatic logic is_legal_op(input logic [3:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_INC, OP_DEC,
      OP_AND, OP_OR, OP_XOR,
      OP_SHL, OP_SHR, OP_SRA, OP_CMP: return 1'b1;
      default:                        return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_pipe_core.sv
// Combinational ALU datapath: one operation in, result plus status flags out.
module alu_core
  import alu_pipe_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       opcode,
  input  logic             cin,
  output logic [WIDTH-1:0] result,
  output flags_t           flags
);

  localparam int SHW = $clog2(WIDTH);

  logic [SHW-1:0]        sh;
  logic [WIDTH:0]        sum;
  logic [WIDTH:0]        diff;
  logic [WIDTH:0]        shl_wide;
  logic [WIDTH:0]        shr_wide;
  logic signed [WIDTH:0] sra_src;
  logic signed [WIDTH:0] sra_wide;

  assign sh       = b[SHW-1:0];
  assign sum      = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
  assign diff     = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, cin};
  // Shifts run one bit wider so the last bit shifted out lands in the guard bit.
  assign shl_wide = {1'b0, a} << sh;
  assign shr_wide = {a, 1'b0} >> sh;
  assign sra_src  = {a, 1'b0};
  assign sra_wide = sra_src >>> sh;

  // Select the operation result and flags; illegal opcodes yield zero with err set.
  always_comb begin
    result         = '0;
    flags          = '0;
    case (opcode)
      OP_ADD: begin
        result          = sum[WIDTH-1:0];
        flags.carry_out = sum[WIDTH];
        flags.overflow  = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        result          = diff[WIDTH-1:0];
        flags.carry_out = diff[WIDTH];
        flags.overflow  = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_INC: begin
        result          = a + 1'b1;
        flags.carry_out = &a;
      end
      OP_DEC: begin
        result          = a - 1'b1;
        flags.carry_out = ~|a;
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_SHL: begin
        result          = shl_wide[WIDTH-1:0];
        flags.carry_out = shl_wide[WIDTH];
      end
      OP_SHR: begin
        result          = shr_wide[WIDTH:1];
        flags.carry_out = shr_wide[0];
      end
      OP_SRA: begin
        result          = sra_wide[WIDTH:1];
        flags.carry_out = sra_wide[0];
      end
      OP_CMP: begin
        result          = {{(WIDTH-1){1'b0}}, (a < b)};
        flags.carry_out = (a == b);
      end
      default: begin
        result = '0;
      end
    endcase
    flags.err  = !is_legal_op(opcode);
    flags.zero = (result == '0);
  end

endmodule

// File: rtl/alu_pipe.sv
// Pipelined ALU: combinational compute feeding a STAGES-deep valid/ready
// register chain with full backpressure.
module alu_pipe
  import alu_pipe_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic [3:0]       opcode,
  input  logic             carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             zero,
  output logic             overflow,
  output logic             err
);

  logic [WIDTH-1:0] core_result;
  flags_t           core_flags;

  logic             vld_q [STAGES];
  logic [WIDTH-1:0] res_q [STAGES];
  flags_t           flg_q [STAGES];
  logic [STAGES-1:0] adv;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .a      (operand_a),
    .b      (operand_b),
    .opcode (opcode),
    .cin    (carry_in),
    .result (core_result),
    .flags  (core_flags)
  );

  // A stage advances when it is empty or the stage after it advances.
  always_comb begin
    logic nxt;
    adv = '0;
    nxt = !vld_q[STAGES-1] || out_ready;
    adv[STAGES-1] = nxt;
    for (int k = STAGES - 2; k >= 0; k--) begin
      nxt    = !vld_q[k] || nxt;
      adv[k] = nxt;
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_first
      // Capture the freshly computed result when stage 0 can move.
      always_ff @(posedge clk) begin
        if (reset) begin
          vld_q[0] <= 1'b0;
          res_q[0] <= '0;
          flg_q[0] <= '0;
        end else if (adv[0]) begin
          vld_q[0] <= in_valid;
          res_q[0] <= core_result;
          flg_q[0] <= core_flags;
        end
      end
    end else begin : g_next
      // Shift the previous stage forward when this stage can move.
      always_ff @(posedge clk) begin
        if (reset) begin
          vld_q[k] <= 1'b0;
          res_q[k] <= '0;
          flg_q[k] <= '0;
        end else if (adv[k]) begin
          vld_q[k] <= vld_q[k-1];
          res_q[k] <= res_q[k-1];
          flg_q[k] <= flg_q[k-1];
        end
      end
    end
  end

  // Held low during reset so nothing is accepted on the reset edge.
  assign in_ready  = !reset && adv[0];
  assign out_valid = vld_q[STAGES-1];
  assign result    = res_q[STAGES-1];
  assign carry_out = flg_q[STAGES-1].carry_out;
  assign zero      = flg_q[STAGES-1].zero;
  assign overflow  = flg_q[STAGES-1].overflow;
  assign err       = flg_q[STAGES-1].err;

endmodule

// File: tb/tb_alu_pipe.sv
// Testbench for alu_pipe: directed vector table, backpressure and reset
// sequences, and a randomized stream against a reference model, on a
// 16-bit/2-stage and an 8-bit/3-stage instance.
module tb_alu_pipe;

  localparam logic [3:0] C_ADD = 4'h0, C_SUB = 4'h1, C_INC = 4'h2, C_DEC = 4'h3,
                         C_AND = 4'h5, C_SHL = 4'h8, C_SHR = 4'h9, C_SRA = 4'hA,
                         C_CMP = 4'hB, C_XOR = 4'h7;

  typedef struct packed {
    logic [15:0] r;
    logic c, z, o, e;
  } exp_t;

  typedef struct {
    bit          sel;
    logic [3:0]  op;
    logic [15:0] a, b;
    logic        cin;
    logic [15:0] r;
    logic        c, z, o, e;
  } vec_t;

  logic clk, reset;

  logic        a_in_valid, a_in_ready, a_cin, a_out_valid, a_out_ready;
  logic [15:0] a_op_a, a_op_b, a_result;
  logic [3:0]  a_opcode;
  logic        a_cout, a_zero, a_ovf, a_err;

  logic        b_in_valid, b_in_ready, b_cin, b_out_valid, b_out_ready;
  logic [7:0]  b_op_a, b_op_b, b_result;
  logic [3:0]  b_opcode;
  logic        b_cout, b_zero, b_ovf, b_err;

  int checks = 0;
  int errors = 0;

  exp_t a_q[$];
  exp_t b_q[$];
  vec_t vecs[$];

  alu_pipe #(.WIDTH(16), .STAGES(2)) dut_a (
    .clk(clk), .reset(reset), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .operand_a(a_op_a), .operand_b(a_op_b), .opcode(a_opcode), .carry_in(a_cin),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .result(a_result),
    .carry_out(a_cout), .zero(a_zero), .overflow(a_ovf), .err(a_err)
  );

  alu_pipe #(.WIDTH(8), .STAGES(3)) dut_b (
    .clk(clk), .reset(reset), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .operand_a(b_op_a), .operand_b(b_op_b), .opcode(b_opcode), .carry_in(b_cin),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .result(b_result),
    .carry_out(b_cout), .zero(b_zero), .overflow(b_ovf), .err(b_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference model from the operation rules, using wide signed arithmetic.
  function automatic exp_t model(input int w, input int shw, input logic [3:0] op,
                                 input logic [15:0] a, input logic [15:0] b, input logic cin);
    longint mask, ua, ub, sa, sb, sh, ci, rr, smin, smax, t;
    exp_t x;
    x    = '0;
    mask = (longint'(1) << w) - 1;
    smax = (longint'(1) << (w - 1)) - 1;
    smin = -(longint'(1) << (w - 1));
    ua   = longint'(a) & mask;
    ub   = longint'(b) & mask;
    sa   = (ua > smax) ? ua - (longint'(1) << w) : ua;
    sb   = (ub > smax) ? ub - (longint'(1) << w) : ub;
    ci   = cin ? 1 : 0;
    sh   = ub & ((longint'(1) << shw) - 1);
    rr   = 0;
    case (op)
      C_ADD: begin
        rr = (ua + ub + ci) & mask;
        x.c = (ua + ub + ci) > mask;
        t = sa + sb + ci;
        x.o = (t > smax) || (t < smin);
      end
      C_SUB: begin
        rr = (ua - ub - ci) & mask;
        x.c = ua < (ub + ci);
        t = sa - sb - ci;
        x.o = (t > smax) || (t < smin);
      end
      C_INC: begin rr = (ua + 1) & mask; x.c = (ua == mask); end
      C_DEC: begin rr = (ua - 1) & mask; x.c = (ua == 0); end
      C_AND: rr = ua & ub;
      4'h6:  rr = ua | ub;
      C_XOR: rr = ua ^ ub;
      C_SHL: begin
        rr = (ua << sh) & mask;
        x.c = (sh != 0) && (((ua >> (w - sh)) & 1) != 0);
      end
      C_SHR: begin
        rr = ua >> sh;
        x.c = (sh != 0) && (((ua >> (sh - 1)) & 1) != 0);
      end
      C_SRA: begin
        rr = (sa >>> sh) & mask;
        x.c = (sh != 0) && (((sa >>> (sh - 1)) & 1) != 0);
      end
      C_CMP: begin rr = (ua < ub) ? 1 : 0; x.c = (ua == ub); end
      default: x.e = 1'b1;
    endcase
    x.r = rr[15:0];
    x.z = (rr == 0);
    return x;
  endfunction

  function automatic logic rdy(input bit s);
    return s ? b_in_ready : a_in_ready;
  endfunction

  function automatic logic ov(input bit s);
    return s ? b_out_valid : a_out_valid;
  endfunction

  function automatic logic [19:0] outs(input bit s);
    return s ? {8'h00, b_result, b_cout, b_zero, b_ovf, b_err}
             : {a_result, a_cout, a_zero, a_ovf, a_err};
  endfunction

  task automatic drive(input bit s, input logic v, input logic [3:0] op,
                       input logic [15:0] a, input logic [15:0] b, input logic cin);
    if (s) begin
      b_in_valid = v; b_opcode = op; b_op_a = a[7:0]; b_op_b = b[7:0]; b_cin = cin;
    end else begin
      a_in_valid = v; a_opcode = op; a_op_a = a; a_op_b = b; a_cin = cin;
    end
  endtask

  task automatic add_vec(input bit s, input logic [3:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic cin, input logic [15:0] r,
                         input logic c, input logic z, input logic o, input logic e);
    vec_t v;
    v.sel = s; v.op = op; v.a = a; v.b = b; v.cin = cin;
    v.r = r; v.c = c; v.z = z; v.o = o; v.e = e;
    vecs.push_back(v);
  endtask

  // One op on an idle pipe: accept, measure latency, compare against table.
  task automatic run_vec(input vec_t v);
    bit got;
    int lat;
    @(posedge clk); #1;
    drive(v.sel, 1'b1, v.op, v.a, v.b, v.cin);
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      got = rdy(v.sel);
    end
    check("vec_accept", 32'(got), 32'd1);
    lat = 0;
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(posedge clk); #1;
      drive(v.sel, 1'b0, v.op, v.a, v.b, v.cin);
      lat++;
      @(negedge clk);
      got = ov(v.sel);
    end
    check(v.sel ? "vec_latency_b" : "vec_latency_a", 32'(lat), v.sel ? 32'd3 : 32'd2);
    check(v.sel ? "vec_out_b" : "vec_out_a", 32'(outs(v.sel)), 32'({v.r, v.c, v.z, v.o, v.e}));
  endtask

  task automatic drain();
    bit done = 0;
    a_in_valid = 1'b0; b_in_valid = 1'b0;
    a_out_ready = 1'b1; b_out_ready = 1'b1;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      done = (a_q.size() == 0) && (b_q.size() == 0) && !a_out_valid && !b_out_valid;
    end
    check("drain_empty", 32'(done), 32'd1);
  endtask

  logic [19:0] a_held, b_held;
  bit          a_hold, b_hold;

  // Scoreboard and stall-stability monitor for the 16-bit instance.
  always @(negedge clk) begin
    if (reset) begin
      a_q.delete();
      a_hold = 0;
    end else begin
      if (a_hold) check("a_stall_hold", 32'({a_out_valid, outs(0)}), 32'({1'b1, a_held}));
      a_hold = a_out_valid && !a_out_ready;
      a_held = outs(0);
      if (a_out_valid && a_out_ready) begin
        if (a_q.size() == 0) check("a_unexpected_out", 32'd1, 32'd0);
        else check("a_stream_out", 32'(outs(0)), 32'(a_q.pop_front()));
      end
      if (a_in_valid && a_in_ready)
        a_q.push_back(model(16, 4, a_opcode, a_op_a, a_op_b, a_cin));
    end
  end

  // Scoreboard and stall-stability monitor for the 8-bit instance.
  always @(negedge clk) begin
    if (reset) begin
      b_q.delete();
      b_hold = 0;
    end else begin
      if (b_hold) check("b_stall_hold", 32'({b_out_valid, outs(1)}), 32'({1'b1, b_held}));
      b_hold = b_out_valid && !b_out_ready;
      b_held = outs(1);
      if (b_out_valid && b_out_ready) begin
        if (b_q.size() == 0) check("b_unexpected_out", 32'd1, 32'd0);
        else check("b_stream_out", 32'(outs(1)), 32'(b_q.pop_front()));
      end
      if (b_in_valid && b_in_ready)
        b_q.push_back(model(8, 3, b_opcode, {8'h00, b_op_a}, {8'h00, b_op_b}, b_cin));
    end
  end

  int n;
  int lat;
  bit got;

  initial begin
    reset = 1'b1;
    drive(0, 1'b0, 4'h0, 16'h0, 16'h0, 1'b0);
    drive(1, 1'b0, 4'h0, 16'h0, 16'h0, 1'b0);
    a_out_ready = 1'b1;
    b_out_ready = 1'b1;

    // sel, op, a, b, cin -> result, carry, zero, overflow, err
    add_vec(0, C_ADD, 16'h0005, 16'h0003, 1'b0, 16'h0008, 1'b0, 1'b0, 1'b0, 1'b0);
    add_vec(0, C_ADD, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0);
    add_vec(0, C_ADD, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b0, 1'b1, 1'b0);
    add_vec(0, C_SUB, 16'h0003, 16'h0005, 1'b0, 16'hFFFE, 1'b1, 1'b0, 1'b0, 1'b0);
    add_vec(0, C_SUB, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b0, 1'b1, 1'b0);
    add_vec(0, C_ADD, 16'h0001, 16'h0001, 1'b1, 16'h0003, 1'b0, 1'b0, 1'b0, 1'b0);
    add_vec(0, C_INC, 16'hFFFF, 16'h1234, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0);
    add_vec(0, C_DEC, 16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b0);
    add_vec(0, C_AND, 16'h00FF, 16'h0F0F, 1'b0, 16'h000F, 1'b0, 1'b0, 1'b0, 1'b0);
    add_vec(0, C_SHL, 16'h8001, 16'h0001, 1'b0, 16'h0002, 1'b1, 1'b0, 1'b0, 1'b0);
    add_vec(0, C_SHR, 16'h0003, 16'h0001, 1'b0, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b0);
    add_vec(0, C_SRA, 16'h8000, 16'h000F, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0);
    add_vec(0, C_SHL, 16'h00F0, 16'h0000, 1'b0, 16'h00F0, 1'b0, 1'b0, 1'b0, 1'b0);
    add_vec(0, C_CMP, 16'h0002, 16'h0002, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0);
    add_vec(0, C_CMP, 16'h0001, 16'h0002, 1'b0, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0);
    add_vec(0, 4'hF,  16'h1234, 16'h5678, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1);
    add_vec(0, C_ADD, 16'h1234, 16'h0001, 1'b0, 16'h1235, 1'b0, 1'b0, 1'b0, 1'b0);
    add_vec(0, 4'h4,  16'hFFFF, 16'hFFFF, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1);
    add_vec(1, C_ADD, 16'h0005, 16'h0003, 1'b0, 16'h0008, 1'b0, 1'b0, 1'b0, 1'b0);
    add_vec(1, C_ADD, 16'h00FF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0);
    add_vec(1, C_ADD, 16'h007F, 16'h0001, 1'b0, 16'h0080, 1'b0, 1'b0, 1'b1, 1'b0);
    add_vec(1, C_SUB, 16'h0003, 16'h0005, 1'b0, 16'h00FE, 1'b1, 1'b0, 1'b0, 1'b0);
    add_vec(1, C_SHL, 16'h0081, 16'h0001, 1'b0, 16'h0002, 1'b1, 1'b0, 1'b0, 1'b0);
    add_vec(1, C_SRA, 16'h0080, 16'h0007, 1'b0, 16'h00FF, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_a_state", 32'({a_in_ready, a_out_valid, outs(0)}), 32'd0);
    check("rst_b_state", 32'({b_in_ready, b_out_valid, outs(1)}), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_release_ready", 32'({a_in_ready, b_in_ready}), 32'b11);

    // Directed vectors.
    foreach (vecs[i]) run_vec(vecs[i]);
    drain();

    // Backpressure on the 16-bit instance: 6 ops, out_ready low for 5 cycles.
    @(posedge clk); #1;
    a_out_ready = 1'b0;
    n = 0;
    for (int c = 0; c < 5; c++) begin
      drive(0, 1'b1, 4'($urandom_range(0, 11)), 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
      @(negedge clk);
      check("bp_in_ready", 32'(a_in_ready), (c < 2) ? 32'd1 : 32'd0);
      if (a_in_ready) n++;
      @(posedge clk); #1;
    end
    check("bp_held_ops", 32'(n), 32'd2);
    a_out_ready = 1'b1;
    @(negedge clk);
    check("bp_full_accept_emit", 32'({a_in_ready, a_out_valid}), 32'b11);
    if (a_in_ready) n++;
    for (int i = 0; i < 20 && n < 6; i++) begin
      @(posedge clk); #1;
      drive(0, 1'b1, 4'($urandom_range(0, 11)), 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
      @(negedge clk);
      if (a_in_ready) n++;
    end
    @(posedge clk); #1;
    check("bp_all_accepted", 32'(n), 32'd6);
    drain();

    // Reset with two ops in flight; a new op right after reset.
    @(posedge clk); #1;
    a_out_ready = 1'b0;
    n = 0;
    drive(0, 1'b1, C_ADD, 16'h1111, 16'h2222, 1'b0);
    for (int i = 0; i < 6 && n < 2; i++) begin
      @(negedge clk);
      if (a_in_ready) n++;
      @(posedge clk); #1;
      drive(0, 1'b1, C_XOR, 16'hAAAA, 16'h5555, 1'b0);
    end
    a_in_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check("rst_mid_in_ready", 32'(a_in_ready), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    a_out_ready = 1'b1;
    drive(0, 1'b1, C_ADD, 16'h0010, 16'h0020, 1'b0);
    @(negedge clk);
    check("rst_mid_after", 32'({a_out_valid, a_in_ready}), 32'b01);
    lat = 0;
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(posedge clk); #1;
      a_in_valid = 1'b0;
      lat++;
      @(negedge clk);
      got = a_out_valid;
    end
    check("rst_new_op", 32'({lat[7:0], outs(0)}), 32'({8'd2, 16'h0030, 4'b0000}));
    drain();

    // Randomized stream on both instances with random backpressure.
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      drive(0, 1'($urandom_range(0, 3) != 0), 4'($urandom), 16'($urandom), 16'($urandom), 1'($urandom));
      drive(1, 1'($urandom_range(0, 3) != 0), 4'($urandom), 16'($urandom), 16'($urandom), 1'($urandom));
      a_out_ready = 1'($urandom_range(0, 9) < 7);
      b_out_ready = 1'($urandom_range(0, 9) < 6);
    end
    @(posedge clk); #1;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
